// File: rtl/fifo_word_packer.sv
// Read-side consumer of the byte FIFO: packs NBYTES consecutive bytes into one word and
// hands it downstream on valid/ready; a flush emits a partial word with per-lane keep flags.
module fifo_word_packer #(
   parameter int NBYTES     = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                  clkr,
   input  logic                  rst,
   input  logic                  e,
   output logic                  RREQ,
   input  logic [7:0]            RD,
   input  logic                  flush,
   output logic [8*NBYTES-1:0]   out_data,
   output logic [NBYTES-1:0]     out_keep,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy
);

   localparam int            CW   = $clog2(NBYTES + 1);
   localparam logic [CW-1:0] FULL = CW'(NBYTES);

   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   inflight_q, inflight_d;
   logic                   flush_pend_q, flush_pend_d;
   logic [8*NBYTES-1:0]    asm_q, asm_d;
   logic [8*NBYTES-1:0]    out_data_q, out_data_d;
   logic [NBYTES-1:0]      out_keep_q, out_keep_d;
   logic                   out_valid_q, out_valid_d;

   logic                   slot_free, full_xfer, part_xfer, flush_done;
   logic [NBYTES-1:0]      part_keep;

   // Credit rule: a byte in flight already owns a lane, so capture never overflows.
   assign RREQ = rst & ~e & ~flush_pend_q &
                 (({1'b0, cnt_q} + {{CW{1'b0}}, inflight_q}) < {1'b0, FULL});

   always_comb begin
      cnt_d        = cnt_q;
      asm_d        = asm_q;
      out_data_d   = out_data_q;
      out_keep_d   = out_keep_q;
      out_valid_d  = out_valid_q;
      inflight_d   = RREQ;
      part_keep    = '0;

      slot_free  = ~out_valid_q | out_ready;
      full_xfer  = (cnt_q == FULL) & slot_free;
      flush_done = flush_pend_q & ~inflight_q & slot_free;
      part_xfer  = flush_done & (cnt_q != '0) & (cnt_q != FULL);

      flush_pend_d = flush_pend_q ? ~flush_done : flush;

      for (int i = 0; i < NBYTES; i++) begin
         if (CW'(i) < cnt_q) part_keep[BIG_ENDIAN ? (NBYTES-1-i) : i] = 1'b1;
      end

      if (inflight_q) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (cnt_q == CW'(BIG_ENDIAN ? (NBYTES-1-i) : i)) asm_d[8*i +: 8] = RD;
         end
         cnt_d = cnt_q + CW'(1);
      end

      if (out_valid_q & out_ready) out_valid_d = 1'b0;

      // Unused lanes of a partial word are already zero since asm clears on every transfer.
      if (full_xfer | part_xfer) begin
         out_data_d  = asm_q;
         out_keep_d  = full_xfer ? {NBYTES{1'b1}} : part_keep;
         out_valid_d = 1'b1;
         cnt_d       = '0;
         asm_d       = '0;
      end
   end

   always_ff @(posedge clkr) begin
      if (!rst) begin
         cnt_q        <= '0;
         inflight_q   <= 1'b0;
         flush_pend_q <= 1'b0;
         asm_q        <= '0;
         out_data_q   <= '0;
         out_keep_q   <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         inflight_q   <= inflight_d;
         flush_pend_q <= flush_pend_d;
         asm_q        <= asm_d;
         out_data_q   <= out_data_d;
         out_keep_q   <= out_keep_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign out_data  = out_data_q;
   assign out_keep  = out_keep_q;
   assign out_valid = out_valid_q;
   assign busy      = (cnt_q != '0) | inflight_q | out_valid_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench: a byte FIFO model feeds little- and big-endian packers side by side;
// expected words are queued as bytes are pushed and compared on each output handshake.
module tb_fifo_word_packer;

   localparam int NB = 4;

   logic          clkr = 1'b0;
   logic          rst = 1'b0;
   logic          e = 1'b1;
   logic [7:0]    RD = 8'h00;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;

   logic          rreq, rreq_be;
   logic [31:0]   od, od_be;
   logic [3:0]    ok, ok_be;
   logic          ov, ov_be, busy, busy_be;

   int            checks = 0;
   int            failures = 0;
   int            consumed = 0;
   int            base = 0;
   logic [31:0]   last_be = '0;

   logic [7:0]    fifo_q[$];
   logic [31:0]   exp_d[$], exp_be_d[$];
   logic [3:0]    exp_k[$], exp_be_k[$];

   fifo_word_packer #(.NBYTES(NB), .BIG_ENDIAN(1'b0)) dut (
      .clkr(clkr), .rst(rst), .e(e), .RREQ(rreq), .RD(RD), .flush(flush),
      .out_data(od), .out_keep(ok), .out_valid(ov), .out_ready(out_ready), .busy(busy));

   fifo_word_packer #(.NBYTES(NB), .BIG_ENDIAN(1'b1)) dut_be (
      .clkr(clkr), .rst(rst), .e(e), .RREQ(rreq_be), .RD(RD), .flush(flush),
      .out_data(od_be), .out_keep(ok_be), .out_valid(ov_be), .out_ready(out_ready), .busy(busy_be));

   always #5 clkr = ~clkr;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      fifo_q.push_back(b);
      e = 1'b0;
   endtask

   // Byte i of b is the i-th byte read from the FIFO.
   task automatic expect_word(input int n, input logic [63:0] b);
      logic [31:0] dl, db;
      logic [3:0]  kl, kb;
      dl = '0; db = '0; kl = '0; kb = '0;
      for (int i = 0; i < n; i++) begin
         dl[8*i +: 8]        = b[8*i +: 8];
         db[8*(NB-1-i) +: 8] = b[8*i +: 8];
         kl[i]               = 1'b1;
         kb[NB-1-i]          = 1'b1;
      end
      exp_d.push_back(dl);    exp_k.push_back(kl);
      exp_be_d.push_back(db); exp_be_k.push_back(kb);
   endtask

   task automatic queue_word(input int n, input logic [63:0] b);
      for (int i = 0; i < n; i++) push_byte(b[8*i +: 8]);
      expect_word(n, b);
   endtask

   // Sample at negedge, then drive the FIFO read data just after the posedge.
   task automatic tick();
      logic grant;
      @(negedge clkr);
      grant = rreq;
      if (ov && out_ready) begin
         if (exp_d.size() == 0) chk("spurious_out", 64'(ov), 64'd0);
         else begin
            chk("data_le", 64'(od), 64'(exp_d.pop_front()));
            chk("keep_le", 64'(ok), 64'(exp_k.pop_front()));
            chk("valid_be", 64'(ov_be), 64'd1);
            chk("data_be", 64'(od_be), 64'(exp_be_d.pop_front()));
            chk("keep_be", 64'(ok_be), 64'(exp_be_k.pop_front()));
            last_be = od_be;
         end
      end
      @(posedge clkr);
      #1;
      if (grant && fifo_q.size() != 0) begin
         RD = fifo_q.pop_front();
         consumed++;
      end
      e = (fifo_q.size() == 0);
   endtask

   task automatic drain();
      for (int k = 0; k < 200 && exp_d.size() != 0; k++) tick();
      chk("drain_pending", 64'(exp_d.size()), 64'd0);
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset state
      tick(); tick();
      chk("rst_valid", 64'(ov), 64'd0);
      chk("rst_keep", 64'(ok), 64'd0);
      chk("rst_data", 64'(od), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      e = 1'b0;
      #1;
      chk("rst_rreq", 64'(rreq), 64'd0);
      chk("rst_rreq_be", 64'(rreq_be), 64'd0);
      e = 1'b1;
      rst = 1'b1;
      out_ready = 1'b1;

      // basic packing
      queue_word(4, 64'h04030201);
      queue_word(4, 64'h08070605);
      drain();
      tick();
      chk("basic_e", 64'(e), 64'd1);
      chk("basic_rreq", 64'(rreq), 64'd0);
      chk("basic_consumed", 64'(consumed), 64'd8);
      tick();
      chk("basic_busy", 64'(busy), 64'd0);

      // big-endian lane order
      queue_word(4, 64'hD4C3B2A1);
      drain();
      chk("be_word", 64'(last_be), 64'hA1B2C3D4);

      // backpressure: one word held, one assembled, then reads stall
      out_ready = 1'b0;
      base = consumed;
      queue_word(4, 64'h24232221);
      queue_word(4, 64'h28272625);
      queue_word(4, 64'h2C2B2A29);
      repeat (10) tick();
      chk("bp_hold_a", 64'(od), 64'h24232221);
      repeat (10) tick();
      chk("bp_hold_b", 64'(od), 64'h24232221);
      chk("bp_keep", 64'(ok), 64'hF);
      chk("bp_valid", 64'(ov), 64'd1);
      chk("bp_rreq", 64'(rreq), 64'd0);
      chk("bp_consumed", 64'(consumed - base), 64'd8);
      out_ready = 1'b1;
      drain();
      chk("bp_total", 64'(consumed - base), 64'd12);

      // flush of a partial word
      queue_word(3, 64'h332211);
      repeat (6) tick();
      chk("fp_wait", 64'(ov), 64'd0);
      pulse_flush();
      drain();
      tick();
      chk("fp_busy", 64'(busy), 64'd0);

      // flush arriving while a read is in flight
      push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
      expect_word(2, 64'h4241);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("fi_rreq_a", 64'(rreq), 64'd0);
      chk("fi_rreq_be", 64'(rreq_be), 64'd0);
      tick();
      chk("fi_rreq_b", 64'(rreq), 64'd0);
      drain();
      expect_word(1, 64'h43);
      repeat (4) tick();
      pulse_flush();
      drain();

      // reset in the middle of a word
      push_byte(8'h51); push_byte(8'h52);
      repeat (4) tick();
      rst = 1'b0;
      tick();
      chk("mr_valid", 64'(ov), 64'd0);
      chk("mr_busy", 64'(busy), 64'd0);
      chk("mr_busy_be", 64'(busy_be), 64'd0);
      rst = 1'b1;
      repeat (3) tick();
      chk("mr_idle", 64'(ov), 64'd0);
      queue_word(4, 64'h64636261);
      drain();

      // flush with nothing held
      pulse_flush();
      repeat (3) tick();
      chk("noop_valid", 64'(ov), 64'd0);
      chk("noop_busy", 64'(busy), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
